// File: rtl/wt_wbuf_merge.sv
// Write-through store buffer: merges same-word stores into one pending entry and
// drains entries in allocation order, with a bounded number of writes outstanding.
module wt_wbuf_merge #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MAX_OUT = 7,
  parameter int TID_W   = $clog2(DEPTH)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  input  logic [ADDR_W-1:0]   st_addr_i,
  input  logic [DATA_W-1:0]   st_data_i,
  input  logic [DATA_W/8-1:0] st_be_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [ADDR_W-1:0]   mem_req_addr_o,
  output logic [DATA_W-1:0]   mem_req_data_o,
  output logic [DATA_W/8-1:0] mem_req_be_o,
  output logic [TID_W-1:0]    mem_req_tid_o,
  input  logic                mem_ack_valid_i,
  input  logic [TID_W-1:0]    mem_ack_tid_i,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  output logic                rd_hit_o,
  input  logic                flush_i,
  output logic                empty_o,
  output logic                full_o
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; valid
  // never depends on ready, and a raised mem_req_valid_o holds with stable fields.
  localparam int BE_W  = DATA_W / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int WA_W  = ADDR_W - OFF;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {ST_INVALID, ST_VALID, ST_PRESENTED, ST_INFLIGHT} ent_state_e;

  ent_state_e        state_q [DEPTH];
  ent_state_e        state_d [DEPTH];
  logic [WA_W-1:0]   waddr_q [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];
  logic [TID_W-1:0]  queue_q [DEPTH];
  logic [TID_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  q_cnt_q;
  logic [OUT_W-1:0]  out_cnt_q;

  logic [WA_W-1:0]  st_waddr, rd_waddr;
  logic [TID_W-1:0] head_idx, merge_idx, alloc_idx;
  logic             req_valid, merge_hit, any_free, all_invalid, hit;
  logic             st_fire, do_merge, do_alloc, issue, ack_ok;
  logic             unused_lsbs;

  assign st_waddr    = st_addr_i[ADDR_W-1:OFF];
  assign rd_waddr    = rd_addr_i[ADDR_W-1:OFF];
  assign unused_lsbs = ^{st_addr_i[OFF-1:0], rd_addr_i[OFF-1:0]};

  assign head_idx  = queue_q[rd_ptr_q];
  assign req_valid = (q_cnt_q != '0)
                   && (state_q[head_idx] == ST_VALID || state_q[head_idx] == ST_PRESENTED)
                   && (out_cnt_q < OUT_W'(MAX_OUT));

  // Entry search; descending scan so the lowest matching index wins. The head
  // is frozen as soon as it is offered, even before its state reads PRESENTED.
  always_comb begin
    merge_hit   = 1'b0;
    merge_idx   = '0;
    any_free    = 1'b0;
    alloc_idx   = '0;
    all_invalid = 1'b1;
    hit         = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (state_q[i] == ST_VALID && waddr_q[i] == st_waddr
          && !(req_valid && head_idx == TID_W'(i))) begin
        merge_hit = 1'b1;
        merge_idx = TID_W'(i);
      end
      if (state_q[i] == ST_INVALID) begin
        any_free  = 1'b1;
        alloc_idx = TID_W'(i);
      end else begin
        all_invalid = 1'b0;
        if (waddr_q[i] == rd_waddr) hit = 1'b1;
      end
    end
  end

  assign st_fire  = st_valid_i && st_ready_o;
  assign do_merge = st_fire && merge_hit;
  assign do_alloc = st_fire && !merge_hit;
  assign issue    = req_valid && mem_req_ready_i;
  assign ack_ok   = mem_ack_valid_i && (state_q[mem_ack_tid_i] == ST_INFLIGHT);

  // Next-state: head, acked and allocated entries are always distinct.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) state_d[i] = state_q[i];
    if (req_valid) state_d[head_idx] = issue ? ST_INFLIGHT : ST_PRESENTED;
    if (ack_ok)    state_d[mem_ack_tid_i] = ST_INVALID;
    if (do_alloc)  state_d[alloc_idx] = ST_VALID;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ST_INVALID;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      q_cnt_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= state_d[i];
      if (do_alloc) wr_ptr_q <= wr_ptr_q + TID_W'(1);
      if (issue)    rd_ptr_q <= rd_ptr_q + TID_W'(1);
      case ({do_alloc, issue})
        2'b10:   q_cnt_q <= q_cnt_q + CNT_W'(1);
        2'b01:   q_cnt_q <= q_cnt_q - CNT_W'(1);
        default: ;
      endcase
      case ({issue, ack_ok})
        2'b10:   out_cnt_q <= out_cnt_q + OUT_W'(1);
        2'b01:   out_cnt_q <= out_cnt_q - OUT_W'(1);
        default: ;
      endcase
    end
  end

  // Payload storage is qualified by entry state, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      if (do_alloc) begin
        queue_q[wr_ptr_q]  <= alloc_idx;
        waddr_q[alloc_idx] <= st_waddr;
        data_q[alloc_idx]  <= st_data_i;
        be_q[alloc_idx]    <= st_be_i;
      end
      if (do_merge) begin
        for (int b = 0; b < BE_W; b++) begin
          if (st_be_i[b]) data_q[merge_idx][8*b +: 8] <= st_data_i[8*b +: 8];
        end
        be_q[merge_idx] <= be_q[merge_idx] | st_be_i;
      end
    end
  end

  always_comb begin
    st_ready_o      = !flush_i && (merge_hit || any_free);
    mem_req_valid_o = req_valid;
    mem_req_addr_o  = {waddr_q[head_idx], {OFF{1'b0}}};
    mem_req_data_o  = data_q[head_idx];
    mem_req_be_o    = be_q[head_idx];
    mem_req_tid_o   = head_idx;
    rd_hit_o        = hit;
    empty_o         = all_invalid;
    full_o          = !any_free;
  end

endmodule

// File: tb/tb_wt_wbuf_merge.sv
// Bench for wt_wbuf_merge: directed scenarios plus random traffic, all checked
// against an entry/queue reference model kept in the bench.
module tb_wt_wbuf_merge;
  localparam int DEPTH   = 8;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int MAX_OUT = 7;
  localparam int TID_W   = 3;
  localparam int BE_W    = 8;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              st_valid, st_ready;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic [BE_W-1:0]   st_be;
  logic              mem_req_valid, mem_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic [BE_W-1:0]   mem_req_be;
  logic [TID_W-1:0]  mem_req_tid;
  logic              ack_valid;
  logic [TID_W-1:0]  ack_tid;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit, flush, empty, full;

  always #5 clk = ~clk;

  wt_wbuf_merge #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .TID_W(TID_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .st_valid_i(st_valid), .st_ready_o(st_ready), .st_addr_i(st_addr),
    .st_data_i(st_data), .st_be_i(st_be),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_ready),
    .mem_req_addr_o(mem_req_addr), .mem_req_data_o(mem_req_data),
    .mem_req_be_o(mem_req_be), .mem_req_tid_o(mem_req_tid),
    .mem_ack_valid_i(ack_valid), .mem_ack_tid_i(ack_tid),
    .rd_addr_i(rd_addr), .rd_hit_o(rd_hit),
    .flush_i(flush), .empty_o(empty), .full_o(full)
  );

  // ---------------- scoreboard / counters ----------------
  int total = 0;
  int bad   = 0;
  logic [TID_W-1:0]  exp_q[$];
  logic [TID_W-1:0]  obs_tid_q[$];
  logic [63:0]       obs_addr_q[$];
  logic [63:0]       obs_data_q[$];
  logic [BE_W-1:0]   obs_be_q[$];
  int                ack_pend[$];
  bit last_ready, last_valid, last_hit, last_full, last_empty;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // An entry is "used" from allocation until its ack; pending entries wait in
  // m_order in allocation order; m_fly marks entries issued but not yet acked.
  logic [63:0]     m_waddr[DEPTH];
  logic [63:0]     m_data[DEPTH];
  logic [BE_W-1:0] m_be[DEPTH];
  bit              m_used[DEPTH];
  bit              m_fly[DEPTH];
  int              m_order[$];

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_used[i]) n++;
    return n;
  endfunction

  function automatic int model_flying();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_fly[i]) n++;
    return n;
  endfunction

  function automatic bit model_valid();
    return (m_order.size() > 0) && (model_flying() < MAX_OUT);
  endfunction

  function automatic int model_merge(input logic [63:0] addr, input bit head_shown);
    for (int k = 0; k < m_order.size(); k++) begin
      if (m_waddr[m_order[k]] == (addr >> 3) && !(k == 0 && head_shown)) return m_order[k];
    end
    return -1;
  endfunction

  function automatic int model_free();
    for (int i = 0; i < DEPTH; i++) if (!m_used[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] be_mask(input logic [BE_W-1:0] be);
    logic [63:0] m;
    for (int b = 0; b < BE_W; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_used[i] = 1'b0;
      m_fly[i]  = 1'b0;
    end
    m_order.delete();
    ack_pend.delete();
  endtask

  // One clock: check outputs at the negedge, advance the model, return after posedge.
  task automatic step();
    int mi, fi, hd;
    bit ev, er, eh, ak;
    logic [63:0] mask;
    @(negedge clk);
    ev = model_valid();
    mi = model_merge(st_addr, ev);
    fi = model_free();
    er = !flush && (mi >= 0 || fi >= 0);
    eh = 1'b0;
    for (int i = 0; i < DEPTH; i++) if (m_used[i] && m_waddr[i] == (rd_addr >> 3)) eh = 1'b1;
    last_ready = st_ready; last_valid = mem_req_valid; last_hit = rd_hit;
    last_full  = full;     last_empty = empty;
    check("st_ready", 64'(st_ready), 64'(er));
    check("req_valid", 64'(mem_req_valid), 64'(ev));
    check("full", 64'(full), 64'(model_count() == DEPTH));
    check("empty", 64'(empty), 64'(model_count() == 0));
    check("rd_hit", 64'(rd_hit), 64'(eh));
    hd = ev ? m_order[0] : 0;
    if (ev) begin
      mask = be_mask(m_be[hd]);
      check("req_tid", 64'(mem_req_tid), 64'(hd));
      check("req_addr", mem_req_addr, m_waddr[hd] << 3);
      check("req_be", 64'(mem_req_be), 64'(m_be[hd]));
      check("req_data", mem_req_data & mask, m_data[hd] & mask);
    end
    if (rst_n && mem_req_valid && mem_ready) begin
      obs_tid_q.push_back(mem_req_tid);
      obs_addr_q.push_back(mem_req_addr);
      obs_data_q.push_back(mem_req_data);
      obs_be_q.push_back(mem_req_be);
    end
    if (!rst_n) model_reset();
    else begin
      ak = ack_valid && m_fly[ack_tid];
      if (st_valid && er) begin
        if (mi >= 0) begin
          for (int b = 0; b < BE_W; b++) if (st_be[b]) m_data[mi][8*b +: 8] = st_data[8*b +: 8];
          m_be[mi] = m_be[mi] | st_be;
        end else begin
          m_used[fi] = 1'b1; m_waddr[fi] = st_addr >> 3;
          m_data[fi] = st_data; m_be[fi] = st_be;
          m_order.push_back(fi);
        end
      end
      if (ev && mem_ready) begin
        void'(m_order.pop_front());
        m_fly[hd] = 1'b1;
        ack_pend.push_back(hd);
      end
      if (ak) begin
        m_fly[ack_tid] = 1'b0; m_used[ack_tid] = 1'b0;
        for (int i = 0; i < ack_pend.size(); i++) begin
          if (ack_pend[i] == int'(ack_tid)) begin ack_pend.delete(i); break; end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    st_valid = 1'b1; st_addr = a; st_data = d; st_be = be;
  endtask

  task automatic idle_st();
    st_valid = 1'b0;
  endtask

  task automatic clear_obs();
    obs_tid_q.delete(); obs_addr_q.delete(); obs_data_q.delete(); obs_be_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ack_valid = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Issue everything and ack each request the cycle after it goes out.
  task automatic drain(input int budget);
    int n = 0;
    mem_ready = 1'b1;
    while (model_count() > 0 && n < budget) begin
      if (ack_pend.size() > 0) begin ack_valid = 1'b1; ack_tid = TID_W'(ack_pend[0]); end
      else ack_valid = 1'b0;
      step();
      n++;
    end
    ack_valid = 1'b0;
    check("drain_in_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic check_order(input string tag);
    check({tag, "_count"}, 64'(obs_tid_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_tid_q.size(); i++)
      check(tag, 64'(obs_tid_q[i]), 64'(exp_q[i]));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    mem_ready = 1'b0; ack_valid = 1'b0; ack_tid = '0; rd_addr = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Reset state
    step();
    check("rst_ready", 64'(last_ready), 64'd1);
    check("rst_valid", 64'(last_valid), 64'd0);
    check("rst_empty", 64'(last_empty), 64'd1);
    check("rst_full", 64'(last_full), 64'd0);
    check("rst_hit", 64'(last_hit), 64'd0);
    flush = 1'b1; step();
    check("rst_flush_ready", 64'(last_ready), 64'd0);
    flush = 1'b0;

    // Merge A: first store is already presented, so the second allocates anew
    do_reset(); clear_obs(); mem_ready = 1'b0;
    set_store(64'h1000, 64'h11111111_AAAAAAAA, 8'h0F); step();
    set_store(64'h1004, 64'hBBBBBBBB_00000000, 8'hF0); step();
    idle_st(); drain(40);
    check("mergeA_issues", 64'(obs_tid_q.size()), 64'd2);
    if (obs_tid_q.size() == 2) begin
      check("mergeA_be0", 64'(obs_be_q[0]), 64'h0F);
      check("mergeA_data0", obs_data_q[0] & 64'h00000000_FFFFFFFF, 64'h00000000_AAAAAAAA);
      check("mergeA_tid1", 64'(obs_tid_q[1]), 64'd1);
      check("mergeA_be1", 64'(obs_be_q[1]), 64'hF0);
    end

    // Merge B: head held by 0x2000, the two 0x1000 stores fold into one entry
    do_reset(); clear_obs(); mem_ready = 1'b0;
    set_store(64'h2000, 64'h22222222_22222222, 8'hFF); step();
    set_store(64'h1000, 64'h11111111_AAAAAAAA, 8'h0F); step();
    set_store(64'h1004, 64'hBBBBBBBB_00000000, 8'hF0); step();
    idle_st(); drain(40);
    check("mergeB_issues", 64'(obs_tid_q.size()), 64'd2);
    if (obs_tid_q.size() == 2) begin
      check("mergeB_tid", 64'(obs_tid_q[1]), 64'd1);
      check("mergeB_addr", obs_addr_q[1], 64'h1000);
      check("mergeB_data", obs_data_q[1], 64'hBBBBBBBB_AAAAAAAA);
      check("mergeB_be", 64'(obs_be_q[1]), 64'hFF);
    end

    // Full / wrap: offset the pointers, then three full rounds
    do_reset(); clear_obs(); mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin set_store(64'h6000 + 64'(8*k), 64'(k), 8'hFF); step(); end
    idle_st(); drain(40);
    for (int r = 0; r < 3; r++) begin
      clear_obs(); mem_ready = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        set_store(64'h7000 + 64'(64*r) + 64'(8*k), {$urandom, $urandom}, 8'hFF);
        step();
        exp_q.push_back(TID_W'(k));
      end
      set_store(64'h7F00, 64'h9, 8'hFF); step();
      check("wrap_full", 64'(last_full), 64'd1);
      check("wrap_ninth_ready", 64'(last_ready), 64'd0);
      idle_st(); drain(60);
      check_order("wrap_order");
    end

    // Outstanding limit
    do_reset(); clear_obs(); mem_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin set_store(64'h8000 + 64'(8*k), 64'(k), 8'hFF); step(); end
    idle_st(); repeat (3) step();
    check("limit_issues", 64'(obs_tid_q.size()), 64'(MAX_OUT));
    check("limit_valid_low", 64'(last_valid), 64'd0);
    ack_valid = 1'b1; ack_tid = TID_W'(ack_pend[0]); step(); ack_valid = 1'b0;
    check("limit_ack_cycle_valid", 64'(last_valid), 64'd0);
    step();
    check("limit_resume_valid", 64'(last_valid), 64'd1);
    check("limit_resume_issues", 64'(obs_tid_q.size()), 64'(MAX_OUT + 1));
    drain(60);

    // Ack while full: store stalls that cycle, lands in the freed entry next cycle
    do_reset(); clear_obs(); mem_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin set_store(64'h9000 + 64'(8*k), 64'(k), 8'hFF); step(); end
    idle_st(); mem_ready = 1'b1; repeat (4) step(); mem_ready = 1'b0;
    set_store(64'h5000, 64'h5555, 8'hFF); ack_valid = 1'b1; ack_tid = 3'd3; step();
    check("sim_stall", 64'(last_ready), 64'd0);
    ack_valid = 1'b0; step();
    check("sim_accept", 64'(last_ready), 64'd1);
    idle_st(); clear_obs();
    exp_q = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd3};
    drain(60);
    check_order("sim_order");
    if (obs_addr_q.size() == 5) check("sim_addr", obs_addr_q[4], 64'h5000);

    // Hazard check against an inflight entry
    do_reset(); clear_obs(); mem_ready = 1'b1;
    set_store(64'h3008, 64'h3, 8'hFF); step();
    idle_st(); step();
    rd_addr = 64'h300C; step(); check("haz_hit", 64'(last_hit), 64'd1);
    rd_addr = 64'h3010; step(); check("haz_miss", 64'(last_hit), 64'd0);
    ack_valid = 1'b1; ack_tid = 3'd0; step(); ack_valid = 1'b0;
    rd_addr = 64'h300C; step(); check("haz_after_ack", 64'(last_hit), 64'd0);

    // Flush drains three entries while blocking a new store
    do_reset(); clear_obs(); mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin set_store(64'hB000 + 64'(8*k), 64'(k), 8'hFF); step(); end
    flush = 1'b1; set_store(64'hB100, 64'h7, 8'hFF); step();
    check("flush_ready", 64'(last_ready), 64'd0);
    drain(40);
    step();
    check("flush_empty", 64'(last_empty), 64'd1);
    check("flush_issues", 64'(obs_tid_q.size()), 64'd3);
    flush = 1'b0; idle_st();

    // Reset with two inflight entries, then a late ack
    do_reset(); clear_obs(); mem_ready = 1'b1;
    set_store(64'hC000, 64'h1, 8'hFF); step();
    set_store(64'hC008, 64'h2, 8'hFF); step();
    idle_st(); step(); mem_ready = 1'b0;
    do_reset(); step();
    check("rstmid_empty", 64'(last_empty), 64'd1);
    check("rstmid_valid", 64'(last_valid), 64'd0);
    ack_valid = 1'b1; ack_tid = 3'd0; step(); ack_valid = 1'b0;
    check("late_ack_empty", 64'(last_empty), 64'd1);
    clear_obs(); mem_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin set_store(64'hD000 + 64'(8*k), 64'(k), 8'hFF); step(); end
    idle_st(); repeat (3) step();
    check("late_ack_limit", 64'(obs_tid_q.size()), 64'(MAX_OUT));
    drain(60);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      int r;
      rst_n = ($urandom_range(0, 399) != 0);
      if (!flush) flush = ($urandom_range(0, 99) == 0);
      else if (model_count() == 0 || $urandom_range(0, 29) == 0) flush = 1'b0;
      if ($urandom_range(0, 2) != 0)
        set_store(64'hA000 + 64'(8 * $urandom_range(0, 5)) + 64'($urandom_range(0, 7)),
                  {$urandom, $urandom}, 8'($urandom_range(0, 255)));
      else idle_st();
      mem_ready = ($urandom_range(0, 3) != 0);
      rd_addr = 64'hA000 + 64'($urandom_range(0, 63));
      r = $urandom_range(0, 9);
      if (r < 6 && ack_pend.size() > 0) begin
        ack_valid = 1'b1; ack_tid = TID_W'(ack_pend[$urandom_range(0, ack_pend.size() - 1)]);
      end else if (r == 9) begin
        ack_valid = 1'b1; ack_tid = TID_W'($urandom_range(0, DEPTH - 1));
      end else ack_valid = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
